// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register: captures decoded instruction and operands,
// bypasses same-cycle writeback, inserts load-use bubbles and honours backpressure/flush.
module id_ex_stage #(
    parameter int DWIDTH = 32,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DWIDTH-1:0] id_pc,
    input  logic [4:0]        id_rs1_id,
    input  logic [4:0]        id_rs2_id,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd_id,
    input  logic [DWIDTH-1:0] id_imm,
    input  logic [CWIDTH-1:0] id_ctrl,
    input  logic [DWIDTH-1:0] rs1_data,
    input  logic [DWIDTH-1:0] rs2_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd_id,
    input  logic [DWIDTH-1:0] wb_data,
    input  logic              ex_mem_read,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [DWIDTH-1:0] ex_pc,
    output logic [DWIDTH-1:0] ex_imm,
    output logic [DWIDTH-1:0] ex_rs1_data,
    output logic [DWIDTH-1:0] ex_rs2_data,
    output logic [4:0]        ex_rs1_id,
    output logic [4:0]        ex_rs2_id,
    output logic [4:0]        ex_rd_id,
    output logic [CWIDTH-1:0] ex_ctrl,
    output logic [15:0]       stall_cnt
);

    logic              adv;
    logic              load_use;
    logic              accept;
    logic              wb_live;
    logic [DWIDTH-1:0] op1;
    logic [DWIDTH-1:0] op2;

    // id_ready must stay independent of rs*_data to keep the reg_file read path short.
    assign adv      = !ex_valid || ex_ready;
    assign load_use = id_valid && ex_valid && ex_mem_read && (ex_rd_id != 5'd0) &&
                      ((id_use_rs1 && (ex_rd_id == id_rs1_id)) ||
                       (id_use_rs2 && (ex_rd_id == id_rs2_id)));
    assign id_ready = adv && !load_use && !flush;
    assign accept   = adv && id_valid && id_ready;

    // reg_file does not qualify its own bypass with we, so x0 and we are checked here.
    assign wb_live  = wb_we && (wb_rd_id != 5'd0);
    assign op1      = (wb_live && (wb_rd_id == id_rs1_id)) ? wb_data : rs1_data;
    assign op2      = (wb_live && (wb_rd_id == id_rs2_id)) ? wb_data : rs2_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1_id   <= '0;
            ex_rs2_id   <= '0;
            ex_rd_id    <= '0;
            ex_ctrl     <= '0;
        end else if (accept) begin
            ex_valid    <= 1'b1;
            ex_pc       <= id_pc;
            ex_imm      <= id_imm;
            ex_rs1_data <= op1;
            ex_rs2_data <= op2;
            ex_rs1_id   <= id_rs1_id;
            ex_rs2_id   <= id_rs2_id;
            ex_rd_id    <= id_rd_id;
            ex_ctrl     <= id_ctrl;
        end else if (adv) begin
            ex_valid <= 1'b0;
        end else begin
            // Held across an execute stall: pick up writebacks that land meanwhile.
            if (wb_live && (wb_rd_id == ex_rs1_id)) begin
                ex_rs1_data <= wb_data;
            end
            if (wb_live && (wb_rd_id == ex_rs2_id)) begin
                ex_rs2_data <= wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (load_use && adv && !flush && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
